// File: rtl/ascon_pack.sv
// Shared definitions for the Ascon-128 controller and datapath: state encoding,
// round-index constants and the registered control-output bundle.
package ascon_pack;

  localparam logic [3:0] ROUND_P12_START = 4'd0;
  localparam logic [3:0] ROUND_P6_START  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;
  localparam logic [3:0] ROUND_PRELAST   = 4'd10;

  typedef enum logic [4:0] {
    IDLE,
    CONF_INIT,
    INIT_RD0,
    INIT_RDS,
    INIT_RD11,
    WAIT_AD,
    AD_RD6,
    AD_RDS,
    AD_RD11,
    WAIT_PT,
    PT_RD6,
    PT_RDS,
    PT_RD11,
    FIN_RD0,
    FIN_RDS,
    FIN_RD11,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic data_ready;
    logic input_mode;
    logic en_reg_state;
    logic xor_data_begin;
    logic xor_key_begin;
    logic xor_key_end;
    logic xor_lsb_end;
    logic en_cipher;
    logic en_tag;
    logic done;
    logic busy;
  } ctrl_out_t;

  // Output decode of a state; the controller registers this for the state it enters.
  function automatic ctrl_out_t state_outputs(input ctrl_state_t s);
    ctrl_out_t o;
    o      = '0;
    o.busy = (s != IDLE);
    case (s)
      INIT_RD0: o.en_reg_state = 1'b1;
      INIT_RDS, AD_RDS, PT_RDS, FIN_RDS, PT_RD11: begin
        o.input_mode   = 1'b1;
        o.en_reg_state = 1'b1;
      end
      INIT_RD11: begin
        o.input_mode   = 1'b1;
        o.en_reg_state = 1'b1;
        o.xor_key_end  = 1'b1;
      end
      WAIT_AD, WAIT_PT: o.data_ready = 1'b1;
      AD_RD6: begin
        o.input_mode     = 1'b1;
        o.en_reg_state   = 1'b1;
        o.xor_data_begin = 1'b1;
      end
      AD_RD11: begin
        o.input_mode   = 1'b1;
        o.en_reg_state = 1'b1;
        o.xor_lsb_end  = 1'b1;
      end
      PT_RD6: begin
        o.input_mode     = 1'b1;
        o.en_reg_state   = 1'b1;
        o.xor_data_begin = 1'b1;
        o.en_cipher      = 1'b1;
      end
      FIN_RD0: begin
        o.input_mode     = 1'b1;
        o.en_reg_state   = 1'b1;
        o.xor_data_begin = 1'b1;
        o.xor_key_begin  = 1'b1;
        o.en_cipher      = 1'b1;
      end
      FIN_RD11: begin
        o.input_mode   = 1'b1;
        o.en_reg_state = 1'b1;
        o.xor_key_end  = 1'b1;
        o.en_tag       = 1'b1;
      end
      DONE: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/round_counter.sv
// 4-bit Ascon round index: loads the p12 or p6 start round, otherwise counts
// 0..11 and wraps. Loads take priority over counting.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       init_p12,
  input  logic       init_p6,
  input  logic       enable,
  output logic [3:0] round
);

  // NOTE: asynchronous active-low reset in the sensitivity list; state updates use <= only.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      round <= ROUND_P12_START;
    end else if (init_p12) begin
      round <= ROUND_P12_START;
    end else if (init_p6) begin
      round <= ROUND_P6_START;
    end else if (enable) begin
      round <= (round == ROUND_LAST) ? ROUND_P12_START : round + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Ascon-128 mode controller: sequences init p12, one AD block, NB_PT_BLOCKS
// plaintext blocks and p12 finalisation on the shared permutation datapath.
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       input_mode_o,
  output logic       en_reg_state_o,
  output logic       xor_data_begin_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_lsb_end_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       done_o,
  output logic       busy_o
);

  localparam logic [3:0] LAST_BLK = 4'(NB_PT_BLOCKS - 1);

  ctrl_state_t state, state_nxt;
  ctrl_out_t   outs;
  logic [3:0]  blk_cnt;
  logic        cipher_valid;
  logic        init_p12, init_p6, en_cpt;
  logic        transfer;

  assign transfer = data_valid_i && data_ready_o;

  round_counter u_round_counter (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .init_p12 (init_p12),
    .init_p6  (init_p6),
    .enable   (en_cpt),
    .round    (round_o)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    init_p12  = 1'b0;
    init_p6   = 1'b0;
    en_cpt    = 1'b0;
    case (state)
      IDLE:      if (start_i) state_nxt = CONF_INIT;
      CONF_INIT: begin
        init_p12  = 1'b1;
        en_cpt    = 1'b1;
        state_nxt = INIT_RD0;
      end
      INIT_RD0: begin
        en_cpt    = 1'b1;
        state_nxt = INIT_RDS;
      end
      INIT_RDS: begin
        en_cpt = 1'b1;
        if (round_o == ROUND_PRELAST) state_nxt = INIT_RD11;
      end
      INIT_RD11: begin
        en_cpt    = 1'b1;
        state_nxt = WAIT_AD;
      end
      WAIT_AD: if (transfer) begin
        init_p6   = 1'b1;
        state_nxt = AD_RD6;
      end
      AD_RD6: begin
        en_cpt    = 1'b1;
        state_nxt = AD_RDS;
      end
      AD_RDS: begin
        en_cpt = 1'b1;
        if (round_o == ROUND_PRELAST) state_nxt = AD_RD11;
      end
      AD_RD11: begin
        en_cpt    = 1'b1;
        state_nxt = WAIT_PT;
      end
      WAIT_PT: if (transfer) begin
        // The final plaintext block is absorbed by the finalisation p12 itself.
        if (blk_cnt < LAST_BLK) begin
          init_p6   = 1'b1;
          state_nxt = PT_RD6;
        end else begin
          init_p12  = 1'b1;
          state_nxt = FIN_RD0;
        end
      end
      PT_RD6: begin
        en_cpt    = 1'b1;
        state_nxt = PT_RDS;
      end
      PT_RDS: begin
        en_cpt = 1'b1;
        if (round_o == ROUND_PRELAST) state_nxt = PT_RD11;
      end
      PT_RD11: begin
        en_cpt    = 1'b1;
        state_nxt = WAIT_PT;
      end
      FIN_RD0: begin
        en_cpt    = 1'b1;
        state_nxt = FIN_RDS;
      end
      FIN_RDS: begin
        en_cpt = 1'b1;
        if (round_o == ROUND_PRELAST) state_nxt = FIN_RD11;
      end
      FIN_RD11: begin
        en_cpt    = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state        <= IDLE;
      outs         <= '0;
      blk_cnt      <= 4'd0;
      cipher_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      outs         <= state_outputs(state_nxt);
      cipher_valid <= outs.en_cipher;
      if (state == PT_RD11) begin
        blk_cnt <= blk_cnt + 4'd1;
      end else if (state == DONE) begin
        blk_cnt <= 4'd0;
      end
    end
  end

  assign data_ready_o     = outs.data_ready;
  assign input_mode_o     = outs.input_mode;
  assign en_reg_state_o   = outs.en_reg_state;
  assign xor_data_begin_o = outs.xor_data_begin;
  assign xor_key_begin_o  = outs.xor_key_begin;
  assign xor_key_end_o    = outs.xor_key_end;
  assign xor_lsb_end_o    = outs.xor_lsb_end;
  assign en_cipher_o      = outs.en_cipher;
  assign en_tag_o         = outs.en_tag;
  assign cipher_valid_o   = cipher_valid;
  assign done_o           = outs.done;
  assign busy_o           = outs.busy;

endmodule
